// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and constants for the IF/MEM memory port arbiter
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} arb_owner_e;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/mem_port_arbiter_streak.sv
// mem_port_arbiter_streak: saturating count of data grants made while a fetch waits
module mem_port_arbiter_streak #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic bump,
    output logic full
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    logic [SW-1:0] count;
    assign full = count == SW'(MAX_DSTREAK);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) count <= '0;
        else if (clear) count <= '0;
        else if (bump && !full) count <= count + SW'(1);
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one outstanding transaction on a shared single-port memory,
// data port has priority, streak limiter keeps instruction fetch from starving
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic [31:0]   if_rdata,
    output logic          if_valid,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_be,
    output logic [31:0]   d_rdata,
    output logic          d_valid,
    output logic          d_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata
);
    arb_state_e state;
    arb_owner_e owner;
    logic kill, streak_full, if_win, idle;
    assign idle = state == ARB_IDLE;
    assign if_win = if_req & ~if_flush & (~d_req | streak_full);
    assign if_stall = if_req & ~if_valid;
    assign d_stall = d_req & ~d_valid;
    mem_port_arbiter_streak #(.MAX_DSTREAK(MAX_DSTREAK)) u_streak (
        .clock (clock),
        .reset (reset),
        .clear (idle & (if_win | ~if_req)),
        .bump  (idle & ~if_win & d_req & if_req),
        .full  (streak_full)
    );
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            owner     <= OWN_NONE;
            kill      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rdata  <= '0;
            if_valid  <= 1'b0;
            d_rdata   <= '0;
            d_valid   <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (if_win) begin
                        state     <= ARB_ISSUE;
                        owner     <= OWN_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= 4'hF;
                    end else if (d_req) begin
                        state     <= ARB_ISSUE;
                        owner     <= OWN_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                    end
                end
                ARB_ISSUE: begin
                    if (owner == OWN_IF && if_flush) kill <= 1'b1;
                    if (mem_gnt) begin
                        state   <= ARB_WAIT;
                        mem_req <= 1'b0;
                    end
                end
                ARB_WAIT: begin
                    if (owner == OWN_IF && if_flush) kill <= 1'b1;
                    if (mem_rvalid) begin
                        state <= ARB_RESP;
                        // a flush arriving with the response must already mask the pulse
                        if (owner == OWN_IF) begin
                            if_rdata <= mem_rdata;
                            if_valid <= ~(kill | if_flush);
                        end else begin
                            d_rdata <= mem_rdata;
                            d_valid <= 1'b1;
                        end
                    end
                end
                ARB_RESP: begin
                    state    <= ARB_IDLE;
                    owner    <= OWN_NONE;
                    kill     <= 1'b0;
                    if_valid <= 1'b0;
                    d_valid  <= 1'b0;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed checks of the memory port arbiter
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int MAXS = 4;
    logic clock = 1'b0;
    logic reset;
    logic if_req, if_flush, if_valid, if_stall;
    logic [AW-1:0] if_addr;
    logic [31:0] if_rdata;
    logic d_req, d_we, d_valid, d_stall;
    logic [AW-1:0] d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic [3:0] d_be;
    logic mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0] mem_be;
    logic r_gnt, r_rvalid, m_gnt, m_rvalid, resp_en, rand_lat;
    int fix_g, fix_r;
    logic [31:0] ram [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];
    logic g_we;
    logic [AW-1:0] g_addr;
    logic [31:0] g_wdata, rw;
    logic [3:0] g_be;
    int n_gnt, rp_ph, rp_cnt, rp_lim;
    int n_chk = 0, n_pass = 0, cyc = 0, ifv_cnt = 0, dv_cnt = 0, d_while_if = 0, max_dwi = 0;
    int seq[$];

    assign mem_gnt = resp_en ? r_gnt : m_gnt;
    assign mem_rvalid = resp_en ? r_rvalid : m_rvalid;

    mem_port_arbiter #(.AW(AW), .MAX_DSTREAK(MAXS)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial forever #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [AW-1:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        if (a == 32'h100) return 32'h5;
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a);
    endfunction

    // memory environment: grants after a delay, acks one or more cycles later
    initial begin
        r_gnt = 0; r_rvalid = 0; mem_rdata = '0; rp_ph = 0; rp_cnt = 0; rp_lim = 0; n_gnt = 0;
        forever begin
            @(posedge clock);
            #1;
            r_gnt = 0;
            r_rvalid = 0;
            if (!reset) begin
                rp_ph = 0;
                rp_cnt = 0;
            end else if (rp_ph == 0) begin
                if (mem_req && resp_en) begin
                    if (rp_cnt == 0) rp_lim = rand_lat ? int'($urandom_range(0, 2)) : fix_g;
                    if (rp_cnt >= rp_lim) begin
                        r_gnt = 1; rp_ph = 1; rp_cnt = 0; n_gnt++;
                        g_we = mem_we; g_addr = mem_addr; g_wdata = mem_wdata; g_be = mem_be;
                    end else rp_cnt++;
                end
            end else begin
                if (rp_cnt == 0) rp_lim = rand_lat ? int'($urandom_range(0, 2)) : fix_r;
                if (rp_cnt >= rp_lim) begin
                    rw = ram.exists(g_addr[31:2]) ? ram[g_addr[31:2]] : init_word(g_addr);
                    mem_rdata = rw;
                    r_rvalid = 1;
                    if (g_we) ram[g_addr[31:2]] = merge(rw, g_wdata, g_be);
                    rp_ph = 0;
                    rp_cnt = 0;
                end else rp_cnt++;
            end
        end
    end

    // completion monitor: order of pulses (1=I, 2=D) and data completions seen while a fetch waits
    always @(negedge clock) begin
        if (if_valid) begin ifv_cnt++; seq.push_back(1); d_while_if = 0; end
        if (d_valid) begin
            dv_cnt++;
            seq.push_back(2);
            if (if_req) begin
                d_while_if++;
                if (d_while_if > max_dwi) max_dwi = d_while_if;
            end
        end
        if (!if_req) d_while_if = 0;
    end

    task automatic drive_if(input logic [AW-1:0] a, output logic [31:0] data, output logic ok, output int lat);
        int c0 = cyc;
        if_req = 1; if_addr = a; ok = 0; data = '0; lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (if_valid) begin ok = 1; data = if_rdata; lat = cyc - c0; break; end
        end
        @(posedge clock); #1;
        if_req = 0;
    endtask

    task automatic drive_d(input logic we, input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] be,
                           output logic [31:0] data, output logic ok, output int lat);
        int c0 = cyc;
        d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_be = be; ok = 0; data = '0; lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (d_valid) begin ok = 1; data = d_rdata; lat = cyc - c0; break; end
        end
        @(posedge clock); #1;
        d_req = 0;
    endtask

    task automatic test_reset;
        reset = 1; if_req = 0; if_flush = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
        d_wdata = '0; d_be = '0; m_gnt = 0; m_rvalid = 0; resp_en = 1; rand_lat = 0; fix_g = 0; fix_r = 0;
        #2 reset = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_chk++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_valid, d_valid, if_rdata, d_rdata, if_stall, d_stall} !== '0)
            $display("FAIL reset_outputs: mem_req=%0b mem_addr=%h mem_be=%h if_valid=%0b d_valid=%0b if_rdata=%h d_rdata=%h, all required 0",
                     mem_req, mem_addr, mem_be, if_valid, d_valid, if_rdata, d_rdata);
        else n_pass++;
        @(posedge clock); #1 reset = 1;
        @(posedge clock); #1;
    endtask

    task automatic test_single_fetch;
        logic [31:0] dat;
        logic ok;
        int lat;
        int dv0 = dv_cnt, iv0 = ifv_cnt;
        fork
            drive_if(32'h10, dat, ok, lat);
            begin
                @(negedge clock);
                n_chk++;
                if (mem_req !== 1'b0) $display("FAIL fetch_mem_req_c0: got %0b required 0", mem_req); else n_pass++;
                @(negedge clock);
                n_chk++;
                if (mem_req !== 1'b1) $display("FAIL fetch_mem_req_c1: got %0b required 1", mem_req); else n_pass++;
            end
        join
        @(posedge clock); #1;
        n_chk++;
        if (!ok || lat != 3) $display("FAIL fetch_latency: ok=%0b got %0d required 3", ok, lat); else n_pass++;
        n_chk++;
        if (dat !== 32'h0050_0093) $display("FAIL fetch_rdata: got %h required 00500093", dat); else n_pass++;
        n_chk++;
        if (g_we !== 1'b0 || g_be !== 4'hF || g_addr !== 32'h10)
            $display("FAIL fetch_payload: we=%0b be=%h addr=%h required 0/f/00000010", g_we, g_be, g_addr);
        else n_pass++;
        n_chk++;
        if (dv_cnt != dv0 || ifv_cnt != iv0 + 1)
            $display("FAIL fetch_pulses: d_valid %0d if_valid %0d required 0 and 1", dv_cnt - dv0, ifv_cnt - iv0);
        else n_pass++;
    endtask

    task automatic test_simultaneous;
        logic [31:0] idat, ddat;
        logic iok, dok;
        int ilat, dlat;
        int s0 = seq.size();
        fork
            drive_if(32'h10, idat, iok, ilat);
            drive_d(1'b0, 32'h100, '0, 4'hF, ddat, dok, dlat);
            for (int i = 0; i < 50; i++) begin
                @(negedge clock);
                if (if_valid) break;
                n_chk++;
                if (if_stall !== 1'b1) $display("FAIL sim_if_stall: cycle %0d got %0b required 1", i, if_stall); else n_pass++;
            end
        join
        n_chk++;
        if (!dok || ddat !== 32'h5) $display("FAIL sim_d_rdata: ok=%0b got %h required 00000005", dok, ddat); else n_pass++;
        n_chk++;
        if (!iok || idat !== 32'h0050_0093) $display("FAIL sim_if_rdata: ok=%0b got %h required 00500093", iok, idat); else n_pass++;
        n_chk++;
        if (seq.size() < s0 + 2 || seq[s0] != 2 || seq[s0+1] != 1)
            $display("FAIL sim_order: got %0d entries, first code %0d required D(2) then I(1)", seq.size() - s0,
                     seq.size() > s0 ? seq[s0] : 0);
        else n_pass++;
    endtask

    task automatic test_starvation;
        int s0 = seq.size();
        int d_left = 6, streak = 0, exp_code = 0, got_code = 0;
        logic if_pend = 1;
        // high-level priority model: data first unless MAXS data grants in a row passed a waiting fetch
        for (int k = 0; k < 7; k++) begin
            if (if_pend && (d_left == 0 || streak == MAXS)) begin
                exp_code = exp_code * 4 + 1; if_pend = 0; streak = 0;
            end else begin
                exp_code = exp_code * 4 + 2; d_left--; if (if_pend) streak++;
            end
        end
        fork
            begin
                logic [31:0] dat;
                logic ok;
                int lat;
                drive_if(32'h2000, dat, ok, lat);
                n_chk++;
                if (!ok || dat !== init_word(32'h2000)) $display("FAIL starve_if_data: got %h required %h", dat, init_word(32'h2000));
                else n_pass++;
            end
            for (int i = 0; i < 6; i++) begin
                logic [31:0] dat, ex;
                logic ok;
                int lat;
                ex = ref_read(32'h1000 + 4 * i);
                drive_d(1'b0, 32'h1000 + 4 * i, '0, 4'hF, dat, ok, lat);
                n_chk++;
                if (!ok || dat !== ex) $display("FAIL starve_d_data[%0d]: got %h required %h", i, dat, ex); else n_pass++;
            end
        join
        for (int k = 0; k < 7; k++) got_code = got_code * 4 + (s0 + k < seq.size() ? seq[s0 + k] : 0);
        n_chk++;
        if (got_code != exp_code) $display("FAIL starve_order: got %h required %h (digits base4, 1=I 2=D)", got_code, exp_code);
        else n_pass++;
    endtask

    task automatic test_store;
        logic [31:0] dat, ex;
        logic ok;
        int lat;
        fork
            drive_d(1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011, dat, ok, lat);
            begin
                @(negedge clock);
                n_chk++;
                if (d_stall !== 1'b1) $display("FAIL store_d_stall: got %0b required 1", d_stall); else n_pass++;
            end
        join
        n_chk++;
        if (!ok || lat != 3) $display("FAIL store_ack: ok=%0b latency %0d required 3", ok, lat); else n_pass++;
        n_chk++;
        if (g_we !== 1'b1 || g_be !== 4'b0011 || g_wdata !== 32'hDEAD_BEEF || g_addr !== 32'h200)
            $display("FAIL store_payload: we=%0b be=%b wdata=%h addr=%h required 1/0011/deadbeef/00000200",
                     g_we, g_be, g_wdata, g_addr);
        else n_pass++;
        ref_mem[30'h80] = merge(ref_read(32'h200), 32'hDEAD_BEEF, 4'b0011);
        ex = ref_read(32'h200);
        drive_d(1'b0, 32'h200, '0, 4'hF, dat, ok, lat);
        n_chk++;
        if (!ok || dat !== ex) $display("FAIL store_readback: got %h required %h", dat, ex); else n_pass++;
    endtask

    task automatic test_flush;
        logic [31:0] dat;
        logic ok, seen;
        int lat, g0, v0;
        fix_r = 3;
        g0 = n_gnt;
        if_req = 1; if_addr = 32'h40; if_flush = 1;
        @(posedge clock); #1;
        n_chk++;
        if (mem_req !== 1'b0) $display("FAIL flush_idle_suppress: mem_req got %0b required 0", mem_req); else n_pass++;
        if_flush = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (mem_gnt) begin seen = 1; break; end
        end
        @(posedge clock); #1;
        n_chk++;
        if (!seen) $display("FAIL flush_wait_gnt: no grant within 20 cycles, required one"); else n_pass++;
        if_flush = 1; if_req = 0;
        @(posedge clock); #1;
        if_flush = 0;
        v0 = ifv_cnt;
        drive_if(32'h80, dat, ok, lat);
        n_chk++;
        if (!ok || dat !== init_word(32'h80)) $display("FAIL flush_new_fetch: got %h required %h", dat, init_word(32'h80));
        else n_pass++;
        n_chk++;
        if (ifv_cnt != v0 + 1) $display("FAIL flush_pulse_count: got %0d if_valid pulses required 1", ifv_cnt - v0); else n_pass++;
        n_chk++;
        if (n_gnt != g0 + 2) $display("FAIL flush_handshakes: got %0d grants required 2", n_gnt - g0); else n_pass++;
        fix_r = 0;
    endtask

    task automatic test_reset_mid;
        int v0, d0;
        resp_en = 0; m_gnt = 0; m_rvalid = 0;
        if_req = 1; if_addr = 32'h44;
        @(posedge clock); #1;
        @(negedge clock);
        n_chk++;
        if (mem_req !== 1'b1) $display("FAIL rstmid_issue: mem_req got %0b required 1", mem_req); else n_pass++;
        #1 reset = 0;
        #1;
        n_chk++;
        if (mem_req !== 1'b0) $display("FAIL rstmid_async: mem_req got %0b required 0", mem_req); else n_pass++;
        @(posedge clock); #1;
        if_req = 0; reset = 1;
        v0 = ifv_cnt; d0 = dv_cnt;
        @(posedge clock); #1 m_rvalid = 1;
        @(posedge clock); #1 m_rvalid = 0;
        repeat (4) @(posedge clock);
        #1;
        n_chk++;
        if (ifv_cnt != v0 || dv_cnt != d0 || mem_req !== 1'b0)
            $display("FAIL rstmid_stray_rvalid: pulses if=%0d d=%0d mem_req=%0b required 0/0/0", ifv_cnt - v0, dv_cnt - d0, mem_req);
        else n_pass++;
        resp_en = 1;
    endtask

    task automatic test_random;
        rand_lat = 1;
        fork
            for (int i = 0; i < 25; i++) begin
                logic [31:0] dat;
                logic [AW-1:0] a;
                logic ok;
                int lat;
                a = 32'h2000 + 4 * $urandom_range(0, 255);
                drive_if(a, dat, ok, lat);
                n_chk++;
                if (!ok || dat !== init_word(a)) $display("FAIL rand_fetch[%0d]: addr %h got %h required %h", i, a, dat, init_word(a));
                else n_pass++;
                repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
            end
            for (int i = 0; i < 25; i++) begin
                logic [31:0] dat, ex, wd;
                logic [AW-1:0] a;
                logic [3:0] be;
                logic ok, we;
                int lat;
                a = 32'h1000 + 4 * $urandom_range(0, 7);
                we = 1'($urandom_range(0, 1));
                wd = $urandom;
                be = 4'($urandom_range(1, 15));
                ex = ref_read(a);
                drive_d(we, a, wd, be, dat, ok, lat);
                if (we) ref_mem[a[31:2]] = merge(ex, wd, be);
                n_chk++;
                if (!ok || (!we && dat !== ex)) $display("FAIL rand_data[%0d]: we=%0b addr %h got %h required %h", i, we, a, dat, ex);
                else n_pass++;
                repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
            end
        join
        n_chk++;
        if (max_dwi > MAXS + 1) $display("FAIL rand_starvation: %0d data completions while fetch waited, limit %0d", max_dwi, MAXS + 1);
        else n_pass++;
        rand_lat = 0;
    endtask

    initial begin
        test_reset;
        test_single_fetch;
        test_simultaneous;
        test_starvation;
        test_store;
        test_flush;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
